riscv_btb_assoc: RTL and testbench
==================================

# riscv_btb_assoc

Parametrised N-way set-associative branch target buffer with per-entry saturating direction counters, round-robin replacement and a sweep-based invalidate FSM. It sits between IF, which does the lookup, and EX, which does the resolve/update. It is the successor to the direct-mapped 2-bit BTB, adding configurable associativity, counter width and flush. Lookup is combinational in the IF cycle. Updates are committed on the next clock edge.

## Interface
- PC_LEN, 32: PC width.
- SETS_LOG2, 8: log2 of set count. SETS = 2**SETS_LOG2.
- WAYS, 2: ways per set, 1..8.
- CNT_WIDTH, 2: saturating counter width, 2..4. CMAX = 2**CNT_WIDTH-1.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  start a full invalidate sweep.
- i_if_pc  in  PC_LEN  fetch PC to predict.
- o_ready  out  1  BTB initialised; lookups and updates are honoured.
- o_pred_valid  out  1  tag hit on a valid entry.
- o_pred_taken  out  1  counter MSB of the hit entry.
- o_pred_target  out  PC_LEN  target of the hit entry.
- i_ex_pc  in  PC_LEN  PC of the resolved control-flow instruction.
- i_ex_target  in  PC_LEN  resolved target.
- i_ex_branch  in  1  conditional branch resolved this cycle.
- i_ex_taken  in  1  branch outcome. Qualified by i_ex_branch.
- i_ex_jump  in  1  unconditional jump resolved this cycle.

## Operation
- Address split (halfword-aligned, RVC-safe):
  - index = pc[SETS_LOG2:1].
  - tag = pc[PC_LEN-1:SETS_LOG2+1], TAG_W = PC_LEN-1-SETS_LOG2.
  - pc[0] is ignored.
- Entry contents: valid, tag[TAG_W], target[PC_LEN], cnt[CNT_WIDTH].
- Per-set state: rr pointer, $clog2(WAYS) bits (0 bits when WAYS=1).
- FSM has two states, INIT and RUN.
  - INIT: sweep counter sc runs from 0 to SETS-1. Each cycle it clears valid of all ways in set sc and resets rr[sc]=0. After sc==SETS-1 the FSM moves to RUN.
  - RUN: o_ready=1.
  - i_flush in RUN moves to INIT with sc=0.
  - i_flush in INIT restarts the sweep at sc=0.
  - i_rst forces INIT, sc=0, from any state, including mid-sweep.
- Lookup:
  - Compare tag against all ways of set index(i_if_pc).
  - Hit = valid && tag equal && o_ready.
  - On hit, o_pred_* come from the hitting way. On no hit, all o_pred_* are 0.
  - Allocation occurs only on miss, so at most one way can hit.
- Update, RUN only. Updates in INIT are dropped.
  - Jump has priority: if i_ex_jump is high, i_ex_branch is ignored.
  - Hit update:
    - target <= i_ex_target.
    - jump: cnt <= CMAX.
    - branch taken: cnt <= min(cnt+1, CMAX).
    - branch not taken: cnt <= max(cnt-1, 0).
    - rr is unchanged.
  - Miss, jump or taken branch: allocate an entry.
    - Victim is the lowest-indexed invalid way. If all ways are valid, the victim is way rr[set], and rr[set] <= (rr+1) mod WAYS.
    - The new entry gets valid=1, tag, target=i_ex_target.
    - cnt = CMAX for a jump; 2**(CNT_WIDTH-1) (weakly taken) for a branch.
  - Miss, not-taken branch: no state change. No allocation.

## Timing
- Lookup: combinational from i_if_pc to o_pred_*. Zero-cycle latency.
- Update: visible to lookups from the cycle after the update is presented.
- Same-cycle lookup and update to the same set: lookup returns pre-update state, unless BTB_BYPASS_EN is defined.
- Reset values:
  - o_ready=0, o_pred_valid=0, o_pred_taken=0, o_pred_target=0.
  - The FSM is in INIT.
  - Entries are not valid until the sweep completes: o_pred_valid stays 0 for SETS cycles after i_rst deasserts.
- o_ready rises exactly SETS cycles after the first clock edge with i_rst=0, and SETS cycles after an i_flush edge.
- Counter arithmetic is CNT_WIDTH-bit unsigned and saturates at both ends. It never wraps.
- rr wraps WAYS-1 -> 0.

## Configuration
- BTB_BYPASS_EN defined:
  - A RUN-state update to tag/index T is forwarded combinationally to a same-cycle lookup of T.
  - For a hit update or an allocation, o_pred_valid=1, o_pred_target=i_ex_target, and o_pred_taken = MSB of the new counter value.
  - A not-taken miss is not forwarded.
- BTB_BYPASS_EN undefined: no forwarding. The update appears next cycle.

## Test plan
- Config SETS_LOG2=8, WAYS=2, CNT_WIDTH=2. Pulse i_rst 1 cycle -> o_ready=0 for 256 cycles, then 1. A lookup during INIT gives o_pred_valid=0. An update during INIT is lost.
- Jump at pc 0x100, target 0x400 -> next cycle, lookup 0x100 gives valid=1, taken=1, target=0x400.
- Branch at pc 0x200, taken -> cnt=2 (taken=1). Not taken, not taken -> cnt=0 (taken=0). A third not-taken keeps cnt=0. Four taken -> cnt=3 and saturates.
- Taken branches at pc 0x200, 0x400, 0x600, all in set 0 with different tags:
  - 0x200 -> way0, 0x400 -> way1.
  - 0x600 evicts way0 (rr 0->1). Lookup 0x200 misses; 0x400 hits.
  - A further taken branch at 0x800 evicts way1 (rr wraps to 0).
- Not-taken branch at unknown pc 0x300 -> no allocation. Next-cycle lookup 0x300 gives valid=0.
- Populate an entry, then pulse i_flush -> o_ready=0 for 256 cycles, then the lookup misses. Asserting i_rst at sweep cycle 100 restarts a full 256-cycle sweep.
- Bypass build: jump update and lookup at 0x100 in the same cycle -> o_pred_valid=1, target=i_ex_target. Non-bypass build -> o_pred_valid=0 that cycle.

Source files
------------

// File: rtl/riscv_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module   : riscv_btb_assoc
// Brief    : N-way set-associative BTB with saturating direction counters,
//            round-robin replacement and a set-by-set invalidate sweep.
//            Optional macro BTB_BYPASS_EN forwards same-cycle updates to lookup.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_btb_assoc #(
    parameter int PC_LEN    = 32,
    parameter int SETS_LOG2 = 8,
    parameter int WAYS      = 2,
    parameter int CNT_WIDTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic [PC_LEN-1:0] i_if_pc,
    output logic              o_ready,
    output logic              o_pred_valid,
    output logic              o_pred_taken,
    output logic [PC_LEN-1:0] o_pred_target,
    input  logic [PC_LEN-1:0] i_ex_pc,
    input  logic [PC_LEN-1:0] i_ex_target,
    input  logic              i_ex_branch,
    input  logic              i_ex_taken,
    input  logic              i_ex_jump
);
    localparam int c_sets  = 2**SETS_LOG2;
    localparam int c_tag_w = PC_LEN - 1 - SETS_LOG2;
    localparam int c_rr_w  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_WIDTH-1:0] c_cmax     = '1;
    localparam logic [CNT_WIDTH-1:0] c_weak     = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic [SETS_LOG2-1:0] c_last_set = '1;

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t               r_state;
    logic [SETS_LOG2-1:0] r_sc;

    logic [WAYS-1:0]      r_valid  [c_sets];
    logic [c_tag_w-1:0]   r_tag    [c_sets][WAYS];
    logic [PC_LEN-1:0]    r_target [c_sets][WAYS];
    logic [CNT_WIDTH-1:0] r_cnt    [c_sets][WAYS];
    logic [c_rr_w-1:0]    r_rr     [c_sets];

    logic [SETS_LOG2-1:0] w_if_idx, w_ex_idx;
    logic [c_tag_w-1:0]   w_if_tag, w_ex_tag;
    logic                 w_ready;
    logic                 w_ex_hit, w_inv_found;
    logic [c_rr_w-1:0]    w_ex_way, w_inv_way, w_way, w_rr_next;
    logic [CNT_WIDTH-1:0] w_hit_cnt, w_new_cnt;
    logic                 w_upd_en, w_write, w_rr_advance;
    logic                 w_unused;

    // Halfword-aligned split: bit 0 never participates
    assign w_if_idx = i_if_pc[SETS_LOG2:1];
    assign w_if_tag = i_if_pc[PC_LEN-1:SETS_LOG2+1];
    assign w_ex_idx = i_ex_pc[SETS_LOG2:1];
    assign w_ex_tag = i_ex_pc[PC_LEN-1:SETS_LOG2+1];
    assign w_unused = ^{i_if_pc[0], i_ex_pc[0]};

    assign w_ready = (r_state == ST_RUN);
    assign o_ready = w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_state <= ST_INIT;
            r_sc    <= '0;
        end else if (r_state == ST_INIT) begin
            r_sc <= r_sc + 1'b1;
            if (r_sc == c_last_set) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Loop runs high-to-low so the lowest-indexed invalid way wins
    always_comb begin
        w_ex_hit    = 1'b0;
        w_ex_way    = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_ex_idx][w] && (r_tag[w_ex_idx][w] == w_ex_tag)) begin
                w_ex_hit = 1'b1;
                w_ex_way = c_rr_w'(w);
            end
            if (!r_valid[w_ex_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_rr_w'(w);
            end
        end
    end

    assign w_hit_cnt = r_cnt[w_ex_idx][w_ex_way];

    always_comb begin
        w_new_cnt = i_ex_jump ? c_cmax : c_weak;
        if (w_ex_hit) begin
            if (i_ex_jump) begin
                w_new_cnt = c_cmax;
            end else if (i_ex_taken) begin
                w_new_cnt = (w_hit_cnt == c_cmax) ? c_cmax : w_hit_cnt + 1'b1;
            end else begin
                w_new_cnt = (w_hit_cnt == '0) ? '0 : w_hit_cnt - 1'b1;
            end
        end
    end

    assign w_upd_en     = w_ready && (i_ex_jump || i_ex_branch);
    assign w_write      = w_upd_en && (w_ex_hit || i_ex_jump || i_ex_taken);
    assign w_way        = w_ex_hit ? w_ex_way : (w_inv_found ? w_inv_way : r_rr[w_ex_idx]);
    assign w_rr_advance = w_write && !w_ex_hit && !w_inv_found;
    assign w_rr_next    = ((WAYS == 1) || (r_rr[w_ex_idx] == c_rr_w'(WAYS - 1))) ?
                          '0 : r_rr[w_ex_idx] + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst && (r_state == ST_INIT)) begin
            r_valid[r_sc] <= '0;
            r_rr[r_sc]    <= '0;
        end else if (w_write) begin
            r_valid[w_ex_idx][w_way]  <= 1'b1;
            r_tag[w_ex_idx][w_way]    <= w_ex_tag;
            r_target[w_ex_idx][w_way] <= i_ex_target;
            r_cnt[w_ex_idx][w_way]    <= w_new_cnt;
            if (w_rr_advance) begin
                r_rr[w_ex_idx] <= w_rr_next;
            end
        end
    end

    always_comb begin
        o_pred_valid  = 1'b0;
        o_pred_taken  = 1'b0;
        o_pred_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_ready && r_valid[w_if_idx][w] && (r_tag[w_if_idx][w] == w_if_tag)) begin
                o_pred_valid  = 1'b1;
                o_pred_taken  = r_cnt[w_if_idx][w][CNT_WIDTH-1];
                o_pred_target = r_target[w_if_idx][w];
            end
        end
`ifdef BTB_BYPASS_EN
        if (w_write && (w_ex_idx == w_if_idx) && (w_ex_tag == w_if_tag)) begin
            o_pred_valid  = 1'b1;
            o_pred_taken  = w_new_cnt[CNT_WIDTH-1];
            o_pred_target = i_ex_target;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_btb_assoc
// Brief    : Directed scoreboard bench for riscv_btb_assoc (SETS_LOG2=8, WAYS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_btb_assoc;
`ifdef BTB_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        rdy;
        logic        v;
        logic        t;
        logic [31:0] tgt;
    } exp_t;

    logic        r_clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        r_flush = 1'b0;
    logic [31:0] r_if_pc = '0;
    logic [31:0] r_ex_pc = '0;
    logic [31:0] r_ex_target = '0;
    logic        r_ex_branch = 1'b0;
    logic        r_ex_taken = 1'b0;
    logic        r_ex_jump = 1'b0;
    logic        r_chk = 1'b0;
    logic        w_ready, w_pv, w_pt;
    logic [31:0] w_ptgt;

    exp_t q[$];
    exp_t r_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    riscv_btb_assoc #(.PC_LEN(32), .SETS_LOG2(8), .WAYS(2), .CNT_WIDTH(2)) dut (
        .i_clk         (r_clk),
        .i_rst         (r_rst),
        .i_flush       (r_flush),
        .i_if_pc       (r_if_pc),
        .o_ready       (w_ready),
        .o_pred_valid  (w_pv),
        .o_pred_taken  (w_pt),
        .o_pred_target (w_ptgt),
        .i_ex_pc       (r_ex_pc),
        .i_ex_target   (r_ex_target),
        .i_ex_branch   (r_ex_branch),
        .i_ex_taken    (r_ex_taken),
        .i_ex_jump     (r_ex_jump)
    );

    always #5 r_clk = ~r_clk;

    always @(negedge r_clk) begin
        if (r_chk) begin
            n_vec++;
            if (q.size() == 0) begin
                n_miss++;
                $display("FAIL no_expect: got rdy=%0b v=%0b t=%0b tgt=%h, want an entry", w_ready, w_pv, w_pt, w_ptgt);
            end else begin
                r_e = q.pop_front();
                if ({w_ready, w_pv, w_pt, w_ptgt} !== {r_e.rdy, r_e.v, r_e.t, r_e.tgt}) begin
                    n_miss++;
                    $display("FAIL %s: got rdy=%0b v=%0b t=%0b tgt=%h, want rdy=%0b v=%0b t=%0b tgt=%h",
                             r_e.name, w_ready, w_pv, w_pt, w_ptgt, r_e.rdy, r_e.v, r_e.t, r_e.tgt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
        r_flush     = 1'b0;
        r_ex_jump   = 1'b0;
        r_ex_branch = 1'b0;
        r_ex_taken  = 1'b0;
        r_chk       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_now(input string nm, input logic [31:0] pc, input logic rdy,
                           input logic v, input logic t, input logic [31:0] tgt);
        exp_t e;
        e.name = nm; e.rdy = rdy; e.v = v; e.t = t; e.tgt = tgt;
        r_if_pc = pc;
        q.push_back(e);
        r_chk = 1'b1;
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic v,
                        input logic t, input logic [31:0] tgt);
        tick();
        chk_now(nm, pc, 1'b1, v, t, tgt);
    endtask

    task automatic branch(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        tick();
        r_ex_branch = 1'b1; r_ex_taken = tk; r_ex_pc = pc; r_ex_target = tgt;
    endtask

    task automatic jump(input logic [31:0] pc, input logic [31:0] tgt);
        tick();
        r_ex_jump = 1'b1; r_ex_pc = pc; r_ex_target = tgt;
    endtask

    // Entered while rst or flush is being presented; j counts edges since then
    task automatic sweep_check(input string nm);
        tick();
        r_rst = 1'b0;
        r_ex_jump = 1'b1; r_ex_pc = 32'h100; r_ex_target = 32'h400;
        chk_now({nm, "_j0"}, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        ticks(155);
        chk_now({nm, "_j155"}, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        ticks(100);
        chk_now({nm, "_j255"}, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_now({nm, "_j256"}, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000ns");
        $fatal(1, "timeout");
    end

    initial begin
        sweep_check("reset");

        // Same-cycle jump and lookup, then next-cycle visibility
        tick();
        r_ex_jump = 1'b1; r_ex_pc = 32'h100; r_ex_target = 32'h400;
        chk_now("same_cycle", 32'h100, 1'b1, c_byp, c_byp, c_byp ? 32'h400 : 32'h0);
        look("jump_hit", 32'h100, 1'b1, 1'b1, 32'h400);

        // Counter walk at 0x200: 2,1,0,0,1,2,3,3,2,1
        branch(32'h200, 32'h2A0, 1'b1); look("br_t1", 32'h200, 1'b1, 1'b1, 32'h2A0);
        branch(32'h200, 32'h2B0, 1'b0); look("br_nt1", 32'h200, 1'b1, 1'b0, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b0); look("br_nt2", 32'h200, 1'b1, 1'b0, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b0); look("br_nt_sat", 32'h200, 1'b1, 1'b0, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b1); look("br_up1", 32'h200, 1'b1, 1'b0, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b1); look("br_up2", 32'h200, 1'b1, 1'b1, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b1); look("br_up3", 32'h200, 1'b1, 1'b1, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b1); look("br_t_sat", 32'h200, 1'b1, 1'b1, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b0); look("br_dn_from_sat", 32'h200, 1'b1, 1'b1, 32'h2B0);
        branch(32'h200, 32'h2B0, 1'b0); look("br_dn2", 32'h200, 1'b1, 1'b0, 32'h2B0);

        // Set 0 replacement: 0x200 in way0, rr=0
        branch(32'h400, 32'h4A0, 1'b1); look("alloc_w1", 32'h400, 1'b1, 1'b1, 32'h4A0);
        branch(32'h600, 32'h6A0, 1'b1);
        look("evict_200", 32'h200, 1'b0, 1'b0, 32'h0);
        look("keep_400", 32'h400, 1'b1, 1'b1, 32'h4A0);
        look("hit_600", 32'h600, 1'b1, 1'b1, 32'h6A0);
        branch(32'h800, 32'h8A0, 1'b1);
        look("evict_400", 32'h400, 1'b0, 1'b0, 32'h0);
        look("hit_800", 32'h800, 1'b1, 1'b1, 32'h8A0);
        look("keep_600", 32'h600, 1'b1, 1'b1, 32'h6A0);
        branch(32'hA00, 32'hAA0, 1'b1);
        look("rr_wrap_evict_600", 32'h600, 1'b0, 1'b0, 32'h0);
        look("hit_A00", 32'hA00, 1'b1, 1'b1, 32'hAA0);
        jump(32'h800, 32'h8B0); look("hit_upd_target", 32'h800, 1'b1, 1'b1, 32'h8B0);
        branch(32'hC00, 32'hCA0, 1'b1);
        look("rr_hold_evict_800", 32'h800, 1'b0, 1'b0, 32'h0);
        look("keep_A00", 32'hA00, 1'b1, 1'b1, 32'hAA0);
        look("hit_C00", 32'hC00, 1'b1, 1'b1, 32'hCA0);

        // Not-taken miss: never allocated, never forwarded
        tick();
        r_ex_branch = 1'b1; r_ex_taken = 1'b0; r_ex_pc = 32'h300; r_ex_target = 32'h3A0;
        chk_now("nt_miss_same", 32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
        look("nt_miss_next", 32'h300, 1'b0, 1'b0, 32'h0);
        look("keep_100", 32'h100, 1'b1, 1'b1, 32'h400);

        tick();
        r_flush = 1'b1;
        sweep_check("flush");

        jump(32'h100, 32'h500); look("post_flush_jump", 32'h100, 1'b1, 1'b1, 32'h500);

        // Reset part-way through a flush sweep restarts the whole sweep
        tick();
        r_flush = 1'b1;
        tick();
        chk_now("flush2_j0", 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        ticks(100);
        r_rst = 1'b1;
        sweep_check("rst_mid");

        branch(32'h200, 32'h250, 1'b1); look("final_alloc", 32'h200, 1'b1, 1'b1, 32'h250);

        ticks(2);
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
